// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//   Shares one sram-like memory port between the instruction-fetch master
//   (inst_*) and the data-access master (data_*). Only one transaction is in
//   flight at a time, and handshakes are routed back only to the master that
//   owns it.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   inst_req/wr/size/addr/wdata   instruction master request side
//   inst_rdata/addr_ok/data_ok    instruction master response side
//   data_req/wr/size/addr/wdata   data master request side
//   data_rdata/addr_ok/data_ok    data master response side
//   mem_req/wr/size/addr/wdata    shared port request side
//   mem_rdata/addr_ok/data_ok     shared port response side
//   busy                          a transaction is owned (state != IDLE)
//
// Parameter
//   ROUND_ROBIN  0: data master wins a tie; 1: master not served last wins.
//
// state  | meaning
// IDLE   | no owner; arbitrate on requests (one bubble cycle)
// ADDR   | owner's request forwarded, waiting for mem_addr_ok
// DATA   | address accepted, waiting for mem_data_ok

module sram_bus_arbiter #(
  parameter int unsigned ROUND_ROBIN = 0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,

  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  owner_t last_owner_q, last_owner_d;

  logic own_req;
  logic req_phase;
  logic fwd_addr_ok;
  logic fwd_data_ok;
  logic own_is_inst;
  logic own_is_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_INST;
      last_owner_q <= OWN_INST;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    req_phase    = 1'b0;
    fwd_addr_ok  = 1'b0;
    fwd_data_ok  = 1'b0;
    own_req      = (owner_q == OWN_DATA) ? data_req : inst_req;

    case (state_q)
      S_IDLE: begin
        if (inst_req && data_req) begin
          state_d = S_ADDR;
          if (ROUND_ROBIN != 0) begin
            owner_d = (last_owner_q == OWN_INST) ? OWN_DATA : OWN_INST;
          end else begin
            owner_d = OWN_DATA;
          end
        end else if (data_req) begin
          state_d = S_ADDR;
          owner_d = OWN_DATA;
        end else if (inst_req) begin
          state_d = S_ADDR;
          owner_d = OWN_INST;
        end
      end

      S_ADDR: begin
        req_phase   = own_req;
        fwd_addr_ok = mem_addr_ok;
        fwd_data_ok = mem_data_ok;
        if (mem_addr_ok && mem_data_ok) begin
          state_d      = S_IDLE;
          last_owner_d = owner_q;
        end else if (mem_addr_ok) begin
          state_d = S_DATA;
        end else if (!own_req) begin
          // Owner withdrew before the address was taken: drop it silently,
          // it was never served so round-robin history stays as it was.
          state_d = S_IDLE;
        end
      end

      S_DATA: begin
        fwd_data_ok = mem_data_ok;
        if (mem_data_ok) begin
          state_d      = S_IDLE;
          last_owner_d = owner_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign own_is_inst = (owner_q == OWN_INST);
  assign own_is_data = (owner_q == OWN_DATA);

  // Handshake outputs are gated by rst so they are quiet in the reset cycle
  // itself, not only after the state register has cleared.
  assign mem_req      = req_phase & ~rst;
  assign busy         = (state_q != S_IDLE) & ~rst;
  assign inst_addr_ok = fwd_addr_ok & own_is_inst & ~rst;
  assign inst_data_ok = fwd_data_ok & own_is_inst & ~rst;
  assign data_addr_ok = fwd_addr_ok & own_is_data & ~rst;
  assign data_data_ok = fwd_data_ok & own_is_data & ~rst;

  // Qualifiers follow the owner at all times; they only matter while mem_req.
  assign mem_wr    = own_is_data ? data_wr    : inst_wr;
  assign mem_size  = own_is_data ? data_size  : inst_size;
  assign mem_addr  = own_is_data ? data_addr  : inst_addr;
  assign mem_wdata = own_is_data ? data_wdata : inst_wdata;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench: two arbiters (fixed-priority and round-robin) share every input.
// A transaction-level model predicts each one's outputs every cycle; a few
// directed scenarios pin the model with literal expectations.

module tb_sram_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [31:0] mem_rdata;
  logic        mem_addr_ok, mem_data_ok;

  logic [31:0] o_inst_rdata [2];
  logic [31:0] o_data_rdata [2];
  logic        o_inst_addr_ok [2];
  logic        o_inst_data_ok [2];
  logic        o_data_addr_ok [2];
  logic        o_data_data_ok [2];
  logic        o_mem_req [2];
  logic        o_mem_wr [2];
  logic [1:0]  o_mem_size [2];
  logic [31:0] o_mem_addr [2];
  logic [31:0] o_mem_wdata [2];
  logic        o_busy [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_bus_arbiter #(.ROUND_ROBIN(g)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .inst_req     (inst_req),
      .inst_wr      (inst_wr),
      .inst_size    (inst_size),
      .inst_addr    (inst_addr),
      .inst_wdata   (inst_wdata),
      .inst_rdata   (o_inst_rdata[g]),
      .inst_addr_ok (o_inst_addr_ok[g]),
      .inst_data_ok (o_inst_data_ok[g]),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_rdata   (o_data_rdata[g]),
      .data_addr_ok (o_data_addr_ok[g]),
      .data_data_ok (o_data_data_ok[g]),
      .mem_req      (o_mem_req[g]),
      .mem_wr       (o_mem_wr[g]),
      .mem_size     (o_mem_size[g]),
      .mem_addr     (o_mem_addr[g]),
      .mem_wdata    (o_mem_wdata[g]),
      .mem_rdata    (mem_rdata),
      .mem_addr_ok  (mem_addr_ok),
      .mem_data_ok  (mem_data_ok),
      .busy         (o_busy[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int m,
                       input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [rr=%0d] t=%0t: got %0h, expected %0h", name, m, $time, act, exp);
    end
  endtask

  // Transaction-level model, one per arbiter (index = ROUND_ROBIN value).
  // Masters: 0 = instruction, 1 = data.
  bit txn_open    [2] = '{0, 0};
  bit addr_taken  [2] = '{0, 0};
  int who         [2] = '{0, 0};
  int last_served [2] = '{0, 0};

  always @(negedge clk) begin : scoreboard
    logic        own_req;
    logic [5:0]  exp_f;
    logic [5:0]  act_f;
    logic [66:0] exp_p;
    for (int m = 0; m < 2; m++) begin
      own_req = (who[m] == 1) ? data_req : inst_req;

      // flags: mem_req, busy, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok
      exp_f = '0;
      if (!rst && txn_open[m]) begin
        exp_f[4] = 1'b1;
        if (!addr_taken[m]) begin
          exp_f[5] = own_req;
          if (who[m] == 1) exp_f[1] = mem_addr_ok;
          else             exp_f[3] = mem_addr_ok;
        end
        if (who[m] == 1) exp_f[0] = mem_data_ok;
        else             exp_f[2] = mem_data_ok;
      end
      act_f = {o_mem_req[m], o_busy[m], o_inst_addr_ok[m], o_inst_data_ok[m],
               o_data_addr_ok[m], o_data_data_ok[m]};
      check("handshake_flags", m, 80'(act_f), 80'(exp_f));
      check("rdata_both", m, 80'({o_inst_rdata[m], o_data_rdata[m]}),
            80'({mem_rdata, mem_rdata}));
      if (exp_f[5]) begin
        exp_p = (who[m] == 1) ? {data_wr, data_size, data_addr, data_wdata}
                              : {inst_wr, inst_size, inst_addr, inst_wdata};
        check("passthrough", m,
              80'({o_mem_wr[m], o_mem_size[m], o_mem_addr[m], o_mem_wdata[m]}),
              80'(exp_p));
      end

      // advance the model across the coming clock edge
      if (rst) begin
        txn_open[m] = 0; addr_taken[m] = 0; who[m] = 0; last_served[m] = 0;
      end else if (!txn_open[m]) begin
        if (inst_req || data_req) begin
          txn_open[m]   = 1;
          addr_taken[m] = 0;
          if (inst_req && data_req) who[m] = (m == 1) ? 1 - last_served[m] : 1;
          else                      who[m] = data_req ? 1 : 0;
        end
      end else if (!addr_taken[m]) begin
        if (mem_addr_ok && mem_data_ok) begin
          txn_open[m] = 0; last_served[m] = who[m];
        end else if (mem_addr_ok) begin
          addr_taken[m] = 1;
        end else if (!own_req) begin
          txn_open[m] = 0;
        end
      end else if (mem_data_ok) begin
        txn_open[m] = 0; last_served[m] = who[m];
      end
    end
  end

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'b10; inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'b10; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    sample();
    check("reset_mem_req", 0, 80'(o_mem_req[0]), 80'(0));
    check("reset_busy", 1, 80'(o_busy[1]), 80'(0));
    next_cycle();
    next_cycle();
    rst = 0;

    // single fetch
    inst_req = 1; inst_addr = 32'h1FC0_0000;
    sample();
    check("fetch_bubble", 0, 80'(o_mem_req[0]), 80'(0));
    next_cycle();
    sample();
    check("fetch_mem_req", 0, 80'(o_mem_req[0]), 80'(1));
    check("fetch_mem_addr", 0, 80'(o_mem_addr[0]), 80'(32'h1FC0_0000));
    next_cycle();
    mem_addr_ok = 1;
    sample();
    check("fetch_addr_ok", 0, 80'({o_inst_addr_ok[0], o_data_addr_ok[0]}), 80'(2'b10));
    next_cycle();
    mem_addr_ok = 0; inst_req = 0;
    sample();
    check("fetch_wait_busy", 0, 80'({o_busy[0], o_mem_req[0]}), 80'(2'b10));
    next_cycle();
    mem_data_ok = 1; mem_rdata = 32'h3C08_0001;
    sample();
    check("fetch_data_ok", 0, 80'({o_inst_data_ok[0], o_data_data_ok[0]}), 80'(2'b10));
    check("fetch_rdata", 0, 80'(o_inst_rdata[0]), 80'(32'h3C08_0001));
    next_cycle();
    mem_data_ok = 0;
    sample();
    check("fetch_done_idle", 0, 80'(o_busy[0]), 80'(0));

    // same-cycle handshake
    data_req = 1; data_addr = 32'h80;
    sample();
    next_cycle();
    mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h55;
    sample();
    check("same_cycle_oks", 0, 80'({o_data_addr_ok[0], o_data_data_ok[0]}), 80'(2'b11));
    next_cycle();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    sample();
    check("same_cycle_idle", 0, 80'(o_busy[0]), 80'(0));

    // tie: fixed priority vs round-robin, one-cycle bubble between grants
    do_reset();
    inst_req = 1; data_req = 1; inst_addr = 32'h100; data_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      sample();
      check("tie_bubble", 0, 80'({o_mem_req[0], o_mem_req[1]}), 80'(2'b00));
      next_cycle();
      mem_addr_ok = 1; mem_data_ok = 1;
      sample();
      check("tie_req_rises", 0, 80'({o_mem_req[0], o_mem_req[1]}), 80'(2'b11));
      check("tie_fixed_owner", 0, 80'({o_inst_addr_ok[0], o_data_addr_ok[0]}), 80'(2'b01));
      check("tie_fixed_addr", 0, 80'(o_mem_addr[0]), 80'(32'h200));
      check("tie_rr_owner", 1, 80'({o_inst_addr_ok[1], o_data_addr_ok[1]}),
            (k % 2 == 0) ? 80'(2'b01) : 80'(2'b10));
      check("tie_rr_addr", 1, 80'(o_mem_addr[1]),
            (k % 2 == 0) ? 80'(32'h200) : 80'(32'h100));
      next_cycle();
      mem_addr_ok = 0; mem_data_ok = 0;
    end
    inst_req = 0; data_req = 0;

    // write passthrough
    data_req = 1; data_wr = 1; data_size = 2'b00; data_addr = 32'h3; data_wdata = 32'hAB;
    sample();
    next_cycle();
    sample();
    check("wr_passthrough", 0,
          80'({o_mem_req[0], o_mem_wr[0], o_mem_size[0], o_mem_addr[0], o_mem_wdata[0]}),
          80'({1'b1, 1'b1, 2'b00, 32'h3, 32'hAB}));
    next_cycle();
    mem_addr_ok = 1;
    sample();
    check("wr_addr_ok", 0, 80'(o_data_addr_ok[0]), 80'(1));
    next_cycle();
    mem_addr_ok = 0;
    sample();
    check("wr_req_drops", 0, 80'({o_mem_req[0], o_busy[0]}), 80'(2'b01));
    next_cycle();
    mem_data_ok = 1; data_req = 0;
    sample();
    check("wr_data_ok", 0, 80'(o_data_data_ok[0]), 80'(1));
    next_cycle();
    mem_data_ok = 0; data_wr = 0;

    // reset while in DATA, then a late data_ok
    inst_req = 1; inst_addr = 32'h40;
    sample();
    next_cycle();
    mem_addr_ok = 1;
    sample();
    next_cycle();
    mem_addr_ok = 0; inst_req = 0;
    sample();
    check("rst_pre_busy", 0, 80'(o_busy[0]), 80'(1));
    next_cycle();
    rst = 1;
    sample();
    check("rst_busy_low", 0, 80'(o_busy[0]), 80'(0));
    next_cycle();
    rst = 0; mem_data_ok = 1;
    sample();
    check("late_data_ok", 0,
          80'({o_inst_data_ok[0], o_data_data_ok[0], o_inst_data_ok[1], o_data_data_ok[1]}),
          80'(4'b0000));
    check("late_busy", 0, 80'({o_busy[0], o_busy[1]}), 80'(2'b00));
    next_cycle();
    mem_data_ok = 0;

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      next_cycle();
      rst         = ($urandom_range(0, 99) == 0);
      inst_req    = ($urandom_range(0, 9) < 6);
      inst_wr     = 1'($urandom);
      inst_size   = 2'($urandom_range(0, 3));
      inst_addr   = $urandom;
      inst_wdata  = $urandom;
      data_req    = ($urandom_range(0, 9) < 6);
      data_wr     = 1'($urandom);
      data_size   = 2'($urandom_range(0, 3));
      data_addr   = $urandom;
      data_wdata  = $urandom;
      mem_addr_ok = ($urandom_range(0, 9) < 4);
      mem_data_ok = ($urandom_range(0, 9) < 3);
      mem_rdata   = $urandom;
    end

    next_cycle();
    rst = 0;
    idle_inputs();
    sample();
    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
